mult_dot_product_seq: RTL and testbench

- Sequencer and accumulator wrapped around the registered unsigned multiplier wrapper (2-cycle operand-to-product latency).
- Accepts operand pairs over a valid/ready stream, drives them into the multiplier, and tracks in-flight products with a tag shift register.
- Accumulates LEN products per vector and presents the dot product on a valid/ready output.
- Sits directly upstream and downstream of the multiplier wrapper: it feeds multiplicand/multiplier and consumes product.

---
 rtl/mult_dot_product_seq.sv | 135 +++++++++++++
 tb/tb_mult_dot_product_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_dot_product_seq.sv
// Purpose : sequences operand pairs into an external registered multiplier and sums LEN products into a dot product.
// Latency : last operand transfer in cycle t -> out_valid in cycle t+2+PIPE_LAT; one result per LEN+PIPE_LAT+2 cycles.
// Backpressure: in_ready drops after LEN pairs until the result is taken; out_valid/out_sum hold while out_ready is low.
// Ports   : clk/rst_n (async active-low); in_valid/in_ready/in_a/in_b operand stream;
//           mul_a/mul_b registered operands to the multiplier, mul_product back from it;
//           out_valid/out_ready/out_sum result stream; busy = vector in progress or result pending.
module mult_dot_product_seq #(
  parameter int WIDTH    = 4,
  parameter int PROD_W   = 2*WIDTH,
  parameter int LEN      = 4,
  parameter int PIPE_LAT = 2,
  parameter int ACC_W    = PROD_W + $clog2(LEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  input  logic [PROD_W-1:0] mul_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              busy
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  acc_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [PIPE_LAT:0] tag;
  logic [PIPE_LAT:0] tag_next;
  logic              fire_in;
  logic              fire_out;
  logic              prod_vld;
  logic              last_issue;
  logic              drain_done;

  assign fire_in    = in_valid && in_ready;
  assign fire_out   = out_valid && out_ready;
  // The oldest tag stage lines up with the product of the matching operand pair.
  assign prod_vld   = tag[PIPE_LAT];
  assign acc_sum    = acc + {{(ACC_W-PROD_W){1'b0}}, mul_product};
  assign last_issue = fire_in && (issue_cnt == LAST);
  // Final product and state change share one edge; out_sum takes acc_sum so that product is kept.
  assign drain_done = (state == DRAIN) && prod_vld && (acc_cnt == LAST);

  always_comb begin
    tag_next    = tag << 1;
    tag_next[0] = fire_in;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ISSUE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state)
      ISSUE: begin
        in_ready = 1'b1;
        busy     = (issue_cnt != '0);
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: begin
        if (drain_done) state_next = DONE;
      end
      DONE: begin
        if (fire_out) state_next = ISSUE;
      end
      default: state_next = ISSUE;
    endcase
  end

  // Datapath: operand registers, tag pipe, accumulator, result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= '0;
      mul_b     <= '0;
      tag       <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      tag <= tag_next;

      if (fire_in) begin
        mul_a     <= in_a;
        mul_b     <= in_b;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end

      if (prod_vld) begin
        acc     <= acc_sum;
        acc_cnt <= acc_cnt + CNT_W'(1);
      end

      if (drain_done) begin
        out_sum   <= acc_sum;
        out_valid <= 1'b1;
      end

      // No products are in flight in DONE, so clearing here cannot drop one.
      if (state == DONE && fire_out) begin
        out_valid <= 1'b0;
        acc       <= '0;
        issue_cnt <= '0;
        acc_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mult_dot_product_seq.sv
module tb_mult_dot_product_seq;

  localparam int WIDTH  = 4;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [WIDTH-1:0]  mul_a;
  logic [WIDTH-1:0]  mul_b;
  logic [PROD_W-1:0] mul_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;

  mult_dot_product_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .busy        (busy)
  );

  // Two-stage registered multiplier standing in for the wrapper.
  logic [PROD_W-1:0] p1;
  logic [PROD_W-1:0] p2;
  always_ff @(posedge clk) begin
    p1 <= mul_a * mul_b;
    p2 <= p1;
  end
  assign mul_product = p2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    #10;
    rst_n = 1'b1;
    tick();

    // 1: 1*5+2*6+3*7+4*8 = 70, back-to-back
    drive(1, 1, 5); tick();
    chk("t1_mul_a0", mul_a, 1);
    chk("t1_mul_b0", mul_b, 5);
    chk("t1_busy", busy, 1);
    drive(1, 2, 6); tick();
    drive(1, 3, 7); tick();
    chk("t1_in_ready_mid", in_ready, 1);
    drive(1, 4, 8); tick();
    drive(0, 0, 0);
    chk("t1_in_ready_drain", in_ready, 0);
    chk("t1_mul_a3", mul_a, 4);
    tick();
    chk("t1_ov_early2", out_valid, 0);
    tick();
    chk("t1_ov_early3", out_valid, 0);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_sum", out_sum, 70);
    chk("t1_in_ready_done", in_ready, 0);
    tick();
    chk("t1_ov_one_cycle", out_valid, 0);
    chk("t1_in_ready_back", in_ready, 1);
    chk("t1_busy_idle", busy, 0);

    // 2: all 15 -> 900
    for (int i = 0; i < 4; i++) begin
      drive(1, 15, 15); tick();
      chk("t2_mul_a", mul_a, 15);
      chk("t2_mul_b", mul_b, 15);
    end
    drive(0, 0, 0);
    tick(); tick(); tick();
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_sum", out_sum, 900);
    tick();
    chk("t2_ov_drop", out_valid, 0);

    // 3: gappy input 1,0,0,1,0,1,1 with a=b=2,3,4,5 -> 54
    drive(1, 2, 2); tick();
    chk("t3_rdy_a", in_ready, 1);
    drive(0, 9, 9); tick();
    chk("t3_rdy_b", in_ready, 1);
    drive(0, 9, 9); tick();
    chk("t3_rdy_c", in_ready, 1);
    drive(1, 3, 3); tick();
    chk("t3_rdy_d", in_ready, 1);
    drive(0, 9, 9); tick();
    chk("t3_rdy_e", in_ready, 1);
    chk("t3_mul_a_hold", mul_a, 3);
    drive(1, 4, 4); tick();
    chk("t3_rdy_f", in_ready, 1);
    drive(1, 5, 5); tick();
    chk("t3_rdy_g", in_ready, 0);
    drive(0, 0, 0);
    tick(); tick(); tick();
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_sum", out_sum, 54);
    tick();

    // 4: stall output for 10 cycles, a=b=3 -> 36, then a=b=1 -> 4
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 3); tick();
    end
    drive(0, 0, 0);
    tick(); tick(); tick();
    chk("t4_out_valid", out_valid, 1);
    chk("t4_out_sum", out_sum, 36);
    for (int i = 0; i < 10; i++) begin
      drive(1, 7, 7); tick();
      chk("t4_stall_ov", out_valid, 1);
      chk("t4_stall_sum", out_sum, 36);
      chk("t4_stall_rdy", in_ready, 0);
    end
    chk("t4_mul_a_no_accept", mul_a, 3);
    drive(0, 0, 0);
    out_ready = 1'b1;
    tick();
    chk("t4_ov_taken", out_valid, 0);
    chk("t4_rdy_issue", in_ready, 1);
    chk("t4_busy_issue", busy, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1); tick();
    end
    drive(0, 0, 0);
    tick(); tick(); tick();
    chk("t4_out_valid2", out_valid, 1);
    chk("t4_out_sum2", out_sum, 4);
    tick();

    // 5: asynchronous reset after two transfers
    drive(1, 3, 3); tick();
    drive(1, 3, 3); tick();
    drive(0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_mul_a", mul_a, 0);
    chk("t5_mul_b", mul_b, 0);
    chk("t5_out_sum", out_sum, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1); tick();
    end
    drive(0, 0, 0);
    tick(); tick(); tick();
    chk("t5_out_valid2", out_valid, 1);
    chk("t5_out_sum2", out_sum, 4);
    tick();

    // 6: two vectors back-to-back, 70 then 900, 8 cycles apart
    drive(1, 1, 5); tick();
    drive(1, 2, 6); tick();
    drive(1, 3, 7); tick();
    drive(1, 4, 8); tick();
    drive(1, 15, 15);
    tick(); tick(); tick();
    chk("t6_ov1", out_valid, 1);
    chk("t6_sum1", out_sum, 70);
    chk("t6_rdy_done", in_ready, 0);
    tick();
    chk("t6_ov1_drop", out_valid, 0);
    chk("t6_rdy_reissue", in_ready, 1);
    tick(); tick(); tick(); tick();
    drive(0, 0, 0);
    chk("t6_rdy_drain2", in_ready, 0);
    tick(); tick();
    chk("t6_ov2_early", out_valid, 0);
    tick();
    chk("t6_ov2", out_valid, 1);
    chk("t6_sum2", out_sum, 900);
    tick();
    chk("t6_ov2_drop", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
